// File: rtl/dose_alarm_pkg.sv
// Shared types and constants for the dose alarm scheduler.
package dose_alarm_pkg;

   localparam int TOD_W  = 17;
   localparam int SLOT_W = 2;
   localparam int DAY_S  = 86400;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZED = 2'd2
   } state_t;

   typedef struct packed {
      logic             valid;
      logic [TOD_W-1:0] sec;
   } slot_t;

   // Next second of day, wrapping at day_s.
   function automatic logic [TOD_W-1:0] tod_inc(input logic [TOD_W-1:0] t, input int day_s);
      return (t == TOD_W'(day_s - 1)) ? '0 : t + 1'b1;
   endfunction

endpackage

// File: rtl/dose_alarm_scheduler_sec_prescaler.sv
// Divides CLOCK_50 down to a one-cycle sec_tick every CLK_HZ cycles.
module sec_prescaler #(
   parameter int CLK_HZ = 50000000
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic clear,
   output logic sec_tick
);

   localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge CLOCK_50) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign sec_tick = (cnt == LAST);

endmodule

// File: rtl/dose_alarm_scheduler.sv
// Dose alarm scheduler: time of day, dose slots, ring/snooze/timeout FSM.
// Optional missed-dose counter enabled by defining DOSE_MISSED_COUNT_EN.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for a valid slot to match the next second
// ST_RINGING | alarm_enable high, ring_sec counting toward timeout
// ST_SNOOZED | tone off, snooze_sec counting down to re-ring
module dose_alarm_scheduler
   import dose_alarm_pkg::*;
#(
   parameter int CLK_HZ    = 50000000,
   parameter int NUM_SLOTS = 4,
   parameter int SNOOZE_S  = 300,
   parameter int TIMEOUT_S = 600,
   parameter int DAY_S     = dose_alarm_pkg::DAY_S
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [SLOT_W-1:0] cfg_slot,
   input  logic [TOD_W-1:0]  cfg_time,
   input  logic              cfg_valid,
   input  logic              time_set,
   input  logic [TOD_W-1:0]  time_value,
   input  logic              ack,
   input  logic              snooze,
   output logic              alarm_enable,
   output logic [SLOT_W-1:0] active_slot,
   output logic [TOD_W-1:0]  tod,
   output logic              dispense_req,
   output logic              missed_dose,
   output logic [7:0]        missed_count
);

   localparam int CNT_W = 16;

   state_t            state;
   slot_t             slots [NUM_SLOTS];
   logic              sec_tick;
   logic              tick;
   logic [TOD_W-1:0]  tod_next;
   logic              match_hit;
   logic [SLOT_W-1:0] match_idx;
   logic [CNT_W-1:0]  ring_sec;
   logic [CNT_W-1:0]  snooze_sec;

   sec_prescaler #(.CLK_HZ(CLK_HZ)) u_sec_prescaler (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .clear    (time_set),
      .sec_tick (sec_tick)
   );

   // A time load swallows a coincident tick so it can never produce a match.
   assign tick = sec_tick & ~time_set;

   always_comb begin
      tod_next = tod_inc(tod, DAY_S);
   end

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      match_hit = 1'b0;
      match_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (slots[i].valid && (slots[i].sec == tod_next)) begin
            match_hit = 1'b1;
            match_idx = SLOT_W'(i);
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slots[i] <= '0;
         end
      end else if (cfg_we) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (cfg_slot == SLOT_W'(i)) begin
               slots[i] <= {cfg_valid, cfg_time};
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         tod <= '0;
      end else if (time_set) begin
         tod <= (time_value >= TOD_W'(DAY_S)) ? '0 : time_value;
      end else if (tick) begin
         tod <= tod_next;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state        <= ST_IDLE;
         active_slot  <= '0;
         ring_sec     <= '0;
         snooze_sec   <= '0;
         dispense_req <= 1'b0;
         missed_dose  <= 1'b0;
      end else begin
         dispense_req <= 1'b0;
         missed_dose  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tick && match_hit) begin
                  state       <= ST_RINGING;
                  active_slot <= match_idx;
                  ring_sec    <= '0;
               end
            end
            ST_RINGING: begin
               if (ack) begin
                  state        <= ST_IDLE;
                  dispense_req <= 1'b1;
               end else if (snooze) begin
                  state      <= ST_SNOOZED;
                  snooze_sec <= CNT_W'(SNOOZE_S);
               end else if (tick) begin
                  if (ring_sec == CNT_W'(TIMEOUT_S - 1)) begin
                     state       <= ST_IDLE;
                     missed_dose <= 1'b1;
                  end else begin
                     ring_sec <= ring_sec + 1'b1;
                  end
               end
            end
            ST_SNOOZED: begin
               if (ack) begin
                  state        <= ST_IDLE;
                  dispense_req <= 1'b1;
               end else if (tick) begin
                  if (snooze_sec == CNT_W'(1)) begin
                     state    <= ST_RINGING;
                     ring_sec <= '0;
                  end else begin
                     snooze_sec <= snooze_sec - 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign alarm_enable = (state == ST_RINGING);

`ifdef DOSE_MISSED_COUNT_EN
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         missed_count <= '0;
      end else if (missed_dose && (missed_count != 8'hFF)) begin
         missed_count <= missed_count + 1'b1;
      end
   end
`else
   assign missed_count = '0;
`endif

endmodule

// File: tb/tb_dose_alarm_scheduler.sv
// Scoreboard bench for dose_alarm_scheduler with a short one-second period.
module tb_dose_alarm_scheduler;

   localparam int EV_RING = 1;
   localparam int EV_DISP = 2;
   localparam int EV_MISS = 3;

   typedef struct {
      int kind;
      int slot;
      int tod;
   } evt_t;

   logic        CLOCK_50;
   logic        reset;
   logic        cfg_we;
   logic [1:0]  cfg_slot;
   logic [16:0] cfg_time;
   logic        cfg_valid;
   logic        time_set;
   logic [16:0] time_value;
   logic        ack;
   logic        snooze;
   logic        alarm_enable;
   logic [1:0]  active_slot;
   logic [16:0] tod;
   logic        dispense_req;
   logic        missed_dose;
   logic [7:0]  missed_count;

   int   n_checks = 0;
   int   n_errors = 0;
   evt_t sb_q[$];
   logic mon_en = 1'b0;
   logic prev_alarm = 1'b0;

   dose_alarm_scheduler #(
      .CLK_HZ    (4),
      .NUM_SLOTS (4),
      .SNOOZE_S  (3),
      .TIMEOUT_S (5),
      .DAY_S     (86400)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .cfg_we       (cfg_we),
      .cfg_slot     (cfg_slot),
      .cfg_time     (cfg_time),
      .cfg_valid    (cfg_valid),
      .time_set     (time_set),
      .time_value   (time_value),
      .ack          (ack),
      .snooze       (snooze),
      .alarm_enable (alarm_enable),
      .active_slot  (active_slot),
      .tod          (tod),
      .dispense_req (dispense_req),
      .missed_dose  (missed_dose),
      .missed_count (missed_count)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_evt(input int kind, input int slot, input int t);
      evt_t e;
      e.kind = kind;
      e.slot = slot;
      e.tod  = t;
      sb_q.push_back(e);
   endtask

   task automatic sb_event(input int kind);
      evt_t e;
      if (sb_q.size() == 0) begin
         chk("sb_unexpected_event", kind, 0);
      end else begin
         e = sb_q.pop_front();
         chk("sb_kind", kind, e.kind);
         if (kind == EV_RING) begin
            chk("sb_ring_slot", {30'd0, active_slot}, e.slot);
            chk("sb_ring_tod", {15'd0, tod}, e.tod);
         end
      end
   endtask

   // Monitor: turns DUT output activity into events and retires them.
   initial begin
      wait (mon_en);
      forever begin
         @(negedge CLOCK_50);
         if (alarm_enable === 1'b1 && prev_alarm !== 1'b1) sb_event(EV_RING);
         if (dispense_req === 1'b1) sb_event(EV_DISP);
         if (missed_dose === 1'b1) sb_event(EV_MISS);
         prev_alarm = alarm_enable;
      end
   end

   task automatic cfg_write(input int slot, input int t, input logic v);
      @(posedge CLOCK_50); #1;
      cfg_we = 1'b1; cfg_slot = 2'(slot); cfg_time = 17'(t); cfg_valid = v;
      @(posedge CLOCK_50); #1;
      cfg_we = 1'b0;
   endtask

   task automatic set_time(input int t);
      @(posedge CLOCK_50); #1;
      time_set = 1'b1; time_value = 17'(t);
      @(posedge CLOCK_50); #1;
      time_set = 1'b0;
   endtask

   task automatic pulse(input logic do_ack, input logic do_snooze);
      @(posedge CLOCK_50); #1;
      ack = do_ack; snooze = do_snooze;
      @(posedge CLOCK_50); #1;
      ack = 1'b0; snooze = 1'b0;
   endtask

   task automatic wait_alarm(input string tag, input int budget);
      int n = 0;
      while (alarm_enable !== 1'b1 && n < budget) begin
         @(negedge CLOCK_50);
         n++;
      end
      chk(tag, alarm_enable, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      reset = 1'b1; cfg_we = 1'b0; cfg_slot = '0; cfg_time = '0; cfg_valid = 1'b0;
      time_set = 1'b0; time_value = '0; ack = 1'b0; snooze = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      #1 reset = 1'b0;
      chk("rst_alarm", alarm_enable, 0);
      chk("rst_tod", tod, 0);
      chk("rst_slot", active_slot, 0);
      chk("rst_disp", dispense_req, 0);
      chk("rst_missed", missed_dose, 0);
      chk("rst_count", missed_count, 0);
      prev_alarm = alarm_enable;
      mon_en = 1'b1;

      // Match and acknowledge
      cfg_write(1, 10, 1'b1);
      expect_evt(EV_RING, 1, 10);
      set_time(8);
      chk("load_tod", tod, 8);
      wait_alarm("ack_ring", 20);
      chk("ack_ring_tod", tod, 10);
      expect_evt(EV_DISP, 0, 0);
      pulse(1'b1, 1'b0);
      chk("ack_alarm_off", alarm_enable, 0);
      chk("ack_disp_now", dispense_req, 1);
      @(posedge CLOCK_50); #1;
      chk("ack_disp_single", dispense_req, 0);

      // Timeout
      expect_evt(EV_RING, 1, 10);
      expect_evt(EV_MISS, 0, 0);
      set_time(8);
      wait_alarm("to_ring", 20);
      cnt = 0;
      while (alarm_enable === 1'b1 && cnt < 40) begin
         cnt++;
         @(negedge CLOCK_50);
      end
      chk("to_ring_len", cnt, 20);
      repeat (2) @(negedge CLOCK_50);
`ifdef DOSE_MISSED_COUNT_EN
      chk("to_missed_count", missed_count, 1);
`else
      chk("to_missed_count", missed_count, 0);
`endif

      // Snooze (second snooze while snoozed must be ignored)
      expect_evt(EV_RING, 1, 10);
      expect_evt(EV_RING, 1, 13);
      set_time(8);
      wait_alarm("sn_ring", 20);
      pulse(1'b0, 1'b1);
      chk("sn_alarm_off", alarm_enable, 0);
      pulse(1'b0, 1'b1);
      chk("sn_still_off", alarm_enable, 0);
      chk("sn_slot_held", active_slot, 1);
      wait_alarm("sn_rering", 40);
      expect_evt(EV_DISP, 0, 0);
      pulse(1'b1, 1'b0);
      chk("sn_ack_off", alarm_enable, 0);

      // Priority and simultaneous ack+snooze
      cfg_write(1, 10, 1'b0);
      cfg_write(0, 20, 1'b1);
      cfg_write(2, 20, 1'b1);
      expect_evt(EV_RING, 0, 20);
      set_time(18);
      wait_alarm("pri_ring", 20);
      expect_evt(EV_DISP, 0, 0);
      pulse(1'b1, 1'b1);
      chk("both_disp", dispense_req, 1);
      chk("both_alarm_off", alarm_enable, 0);
      repeat (20) @(posedge CLOCK_50);
      #1 chk("both_stays_idle", alarm_enable, 0);

      // Wrap and time loads
      cfg_write(3, 0, 1'b1);
      expect_evt(EV_RING, 3, 0);
      set_time(86399);
      chk("wrap_load", tod, 86399);
      wait_alarm("wrap_ring", 12);
      chk("wrap_tod", tod, 0);
      expect_evt(EV_DISP, 0, 0);
      pulse(1'b1, 1'b0);
      set_time(0);
      chk("zero_load_tod", tod, 0);
      repeat (12) @(posedge CLOCK_50);
      #1 chk("zero_no_ring", alarm_enable, 0);
      set_time(86400);
      chk("clamp_86400", tod, 0);
      set_time(100000);
      chk("clamp_100000", tod, 0);

      // Reset mid-ring, with a write to the active slot first
      expect_evt(EV_RING, 3, 0);
      set_time(86399);
      wait_alarm("rr_ring", 12);
      cfg_write(3, 5, 1'b0);
      chk("rr_write_keeps_ring", alarm_enable, 1);
      chk("rr_write_keeps_slot", active_slot, 3);
      @(posedge CLOCK_50); #1;
      reset = 1'b1;
      @(posedge CLOCK_50); #1;
      chk("rr_alarm", alarm_enable, 0);
      chk("rr_tod", tod, 0);
      chk("rr_slot", active_slot, 0);
      chk("rr_disp", dispense_req, 0);
      chk("rr_missed", missed_dose, 0);
      chk("rr_count", missed_count, 0);
      reset = 1'b0;
      set_time(19);
      repeat (12) @(posedge CLOCK_50);
      #1 chk("rr_slots_cleared", alarm_enable, 0);
      chk("rr_tod_runs", tod, 22);

      repeat (2) @(posedge CLOCK_50);
      chk("sb_pending", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
